// File: rtl/alu_share_if.sv
// Requester-side request/response bus of the shared-ALU arbiter.
// Two requesters are carried side by side; per-port bits are indexed by port number.
interface alu_share_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 4
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [XLEN-1:0] req_a0;
  logic [XLEN-1:0] req_a1;
  logic [XLEN-1:0] req_b0;
  logic [XLEN-1:0] req_b1;
  logic [OP_W-1:0] req_op0;
  logic [OP_W-1:0] req_op1;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [XLEN-1:0] rsp_result;
  logic            rsp_illegal;

  modport master (
    output req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_illegal
  );

  modport slave (
    input  req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_illegal
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Each accepted op walks IDLE -> EXEC -> RESP; operands and result are registered.
module alu_share_arbiter #(
  parameter int XLEN = 32,
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_share_if.slave      bus,
  output logic [XLEN-1:0] alu_term_a,
  output logic [XLEN-1:0] alu_term_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [XLEN-1:0] alu_result,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] OP_LAST = OP_W'(4'b1010);

  state_t          state_reg, state_next;
  logic            last_grant_reg;
  logic            owner_reg;
  logic [XLEN-1:0] a_reg, b_reg;
  logic [OP_W-1:0] op_reg;
  logic [XLEN-1:0] result_reg;
  logic            illegal_reg;

  logic [1:0]      grant;
  logic            accept;
  logic            sel;
  logic [XLEN-1:0] a_sel, b_sel;
  logic [OP_W-1:0] op_sel;

  // With both ports pending, the port that did not win last time goes next.
  always_comb begin
    grant = 2'b00;
    case (bus.req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      localparam bit IDX = (gi == 1);
      assign bus.req_ready[gi] = (state_reg == IDLE) & grant[gi];
      assign bus.rsp_valid[gi] = (state_reg == RESP) & (owner_reg == IDX);
    end
  endgenerate

  assign accept = |(bus.req_valid & bus.req_ready);
  assign sel    = bus.req_ready[1];
  assign a_sel  = sel ? bus.req_a1  : bus.req_a0;
  assign b_sel  = sel ? bus.req_b1  : bus.req_b0;
  assign op_sel = sel ? bus.req_op1 : bus.req_op0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (bus.rsp_ready[owner_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
      op_reg         <= '0;
      result_reg     <= '0;
      illegal_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && accept) begin
        a_reg          <= a_sel;
        b_reg          <= b_sel;
        op_reg         <= op_sel;
        owner_reg      <= sel;
        last_grant_reg <= sel;
      end
      if (state_reg == EXEC) begin
        result_reg  <= alu_result;
        illegal_reg <= (op_reg > OP_LAST);
      end
    end
  end

  assign alu_term_a      = a_reg;
  assign alu_term_b      = b_reg;
  assign alu_op          = op_reg;
  assign bus.rsp_result  = result_reg;
  assign bus.rsp_illegal = illegal_reg;
  assign busy            = (state_reg != IDLE);

endmodule
